pll_lock_supervisor: RTL
========================

# pll_lock_supervisor

Parametrised supervisor for the EF2 PLL wrappers. It runs on the free-running reference clock and drives the PLL `reset` input. It monitors `extlock` and qualifies lock with a stability window, then releases N downstream domain resets in a fixed index order. On lock loss or lock timeout it re-arms the PLL automatically, counting each event.

## Interface
- `N_RST`, 2: number of sequenced domain reset outputs (1..8).
- `RST_PULSE`, 16: cycles `pll_rst` is held high per PLL reset attempt (≥2).
- `LOCK_WAIT`, 65536: cycles allowed for synchronised `extlock` to rise before retry.
- `STABLE_CYC`, 1024: cycles synchronised `extlock` must stay high before lock is declared.
- `SEQ_GAP`, 8: cycles between successive `rst_out` releases (≥1).
- `refclk` input 1: reference clock, the only clock.
- `reset` input 1: asynchronous, active-high reset.
- `extlock` input 1: PLL lock flag, asynchronous to `refclk`.
- `pll_rst` output 1: PLL reset, active high.
- `locked` output 1: qualified lock, high only in RUN.
- `rst_out` output N_RST: per-domain resets, active high; bit 0 is released first.
- `lock_lost` output 1: one-cycle pulse on lock loss in RUN.
- `relock_cnt` output 8: saturating count of timeouts plus lock losses.

## Operation
- `extlock` passes through a 2-FF synchroniser to give `lock_s`. The FSM uses only `lock_s`.
- One down/up counter `cnt` is shared by all states, sized to max(LOCK_WAIT, STABLE_CYC, RST_PULSE, SEQ_GAP). It is cleared on every state entry.
- States and transitions:
  - PLL_RST: `pll_rst`=1. After RST_PULSE cycles, go to WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0.
    - `lock_s`=1: go to STABLE.
    - `cnt` reaches LOCK_WAIT-1 with `lock_s`=0: increment `relock_cnt`, go to PLL_RST.
  - STABLE:
    - `lock_s`=0 on any cycle: go to WAIT_LOCK. No count is taken, and the timeout restarts.
    - `lock_s` held high for STABLE_CYC consecutive cycles: go to SEQ.
  - SEQ: a release index `idx` starts at 0.
    - `rst_out[idx]` is cleared, then the FSM waits SEQ_GAP cycles before the next index.
    - After index N_RST-1 is released, go to RUN.
    - `lock_s`=0 during SEQ is handled the same as lock loss in RUN.
  - RUN: `locked`=1.
    - `lock_s`=0: in the same cycle, set all `rst_out` high, drop `locked`, pulse `lock_lost`, and increment `relock_cnt`. Next state is PLL_RST.
- `relock_cnt` saturates at 255 and clears only on `reset`.
- `rst_out` bits, once released, stay low until a lock loss or `reset`. Releases are never reordered.

## Timing
- Reset values: state PLL_RST, `pll_rst`=1, `rst_out`=all ones, `locked`=0, `lock_lost`=0, `relock_cnt`=0, synchroniser=0.
- All outputs are registered. `rst_out` and `pll_rst` assert asynchronously with `reset` and deassert synchronously.
- `pll_rst` stays high for exactly RST_PULSE cycles after the first `refclk` edge following `reset` deassertion.
- `extlock` rising reaches the FSM 2 cycles later.
- Without glitches, `rst_out[0]` falls STABLE_CYC+1 cycles after `lock_s` rises.
- `rst_out[i]` falls `i*SEQ_GAP` cycles after `rst_out[0]`.
- `locked` rises 1 cycle after the last `rst_out` bit falls.
- Lock loss: `lock_lost`, `rst_out` high, and `locked` low all appear 1 cycle after `lock_s` falls, which is 3 cycles after `extlock` falls.
- `reset` asserted in any state immediately forces the reset values, including mid-SEQ.
- The counter never wraps. Each state exits on its terminal count.

## Structure
- Shared package `pll_sup_pkg`:
  - state enum (PLL_RST, WAIT_LOCK, STABLE, SEQ, RUN);
  - `RELOCK_W`=8;
  - function returning the counter width from the parameters.
- One sub-module, `sync_2ff`: a single-bit two-flop synchroniser with asynchronous active-high reset. It is reused by other clock-domain logic.
- The top level holds the FSM, the counter, the `rst_out` register and `relock_cnt`.

## Test plan
Parameters for all cases: N_RST=3, RST_PULSE=4, LOCK_WAIT=100, STABLE_CYC=20, SEQ_GAP=3.
- Clean power-up: `extlock` rises 10 cycles after `pll_rst` falls.
  - Required: `pll_rst` high for 4 cycles.
  - Required: `rst_out` goes 111→110→100→000 at gaps of 3 cycles.
  - Required: `locked`=1 and `relock_cnt`=0.
- Timeout: `extlock` held low.
  - Required: `pll_rst` re-pulses every 104 cycles.
  - Required: `relock_cnt` increments on each retry and saturates at 255 after 255 retries.
- Glitch in STABLE: `extlock` drops for 1 cycle at count 15.
  - Required: `rst_out` stays 111.
  - Required: release occurs 20 stable cycles after recovery, and `relock_cnt` is unchanged.
- Lock loss in RUN: `extlock` falls.
  - Required: 3 cycles later `rst_out`=111, `locked`=0, and `lock_lost` pulses for exactly 1 cycle.
  - Required: `relock_cnt`=1, then the full sequence repeats.
- Lock loss mid-SEQ, with `rst_out`=100.
  - Required: all bits return to 111, `lock_lost` pulses, and the FSM enters PLL_RST.
- Async `reset` pulse of 0.3 cycle during RUN.
  - Required: all outputs take their reset values immediately.
  - Required: `relock_cnt`=0, and `pll_rst` is high for 4 cycles after release.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
// The counter width is derived from the longest interval any state must time.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    SEQ,
    RUN
  } sup_state_t;

  localparam int RELOCK_W = 8;

  // Width of the shared counter: it must hold (longest interval - 1).
  function automatic int cnt_width(input int lock_wait, input int stable_cyc,
                                   input int rst_pulse, input int seq_gap);
    int m;
    m = lock_wait;
    if (stable_cyc > m) m = stable_cyc;
    if (rst_pulse > m) m = rst_pulse;
    if (seq_gap > m) m = seq_gap;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset.
// Shared by any logic that samples a level from a foreign clock domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments keep meta and q as two distinct flops;
  // blocking ones here would collapse the chain into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies extlock over a stability
// window, releases downstream resets in index order and re-arms on loss/timeout.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int N_RST      = 2,
  parameter int RST_PULSE  = 16,
  parameter int LOCK_WAIT  = 65536,
  parameter int STABLE_CYC = 1024,
  parameter int SEQ_GAP    = 8
) (
  input  logic                refclk,
  input  logic                reset,
  input  logic                extlock,
  output logic                pll_rst,
  output logic                locked,
  output logic [N_RST-1:0]    rst_out,
  output logic                lock_lost,
  output logic [RELOCK_W-1:0] relock_cnt
);

  localparam int CNT_W = cnt_width(LOCK_WAIT, STABLE_CYC, RST_PULSE, SEQ_GAP);
  localparam int IDX_W = (N_RST > 1) ? $clog2(N_RST) : 1;

  localparam logic [CNT_W-1:0] PULSE_END  = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] WAIT_END   = CNT_W'(LOCK_WAIT - 1);
  localparam logic [CNT_W-1:0] STABLE_END = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_END    = CNT_W'(SEQ_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_RST - 1);
  localparam logic [N_RST-1:0] BIT0       = N_RST'(1);

  sup_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             armed;
  logic             lock_s;
  logic             lose;
  logic             timeout;
  logic             bump;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (reset),
    .d   (extlock),
    .q   (lock_s)
  );

  // NOTE: every output of this block is assigned on every pass, so no latch
  // can be inferred even as states are added.
  always_comb begin
    lose    = !lock_s && (state == SEQ || state == RUN);
    timeout = !lock_s && (state == WAIT_LOCK) && (cnt == WAIT_END);
    bump    = lose || timeout;
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state      <= PLL_RST;
      cnt        <= '0;
      idx        <= '0;
      armed      <= 1'b0;
      pll_rst    <= 1'b1;
      rst_out    <= '1;
      locked     <= 1'b0;
      lock_lost  <= 1'b0;
      relock_cnt <= '0;
    end else begin
      lock_lost <= 1'b0;
      if (bump && relock_cnt != '1) relock_cnt <= relock_cnt + RELOCK_W'(1);

      if (lose) begin
        state     <= PLL_RST;
        cnt       <= '0;
        pll_rst   <= 1'b1;
        rst_out   <= '1;
        locked    <= 1'b0;
        lock_lost <= 1'b1;
      end else begin
        case (state)
          // The first edge after reset release is treated as the state entry.
          PLL_RST: begin
            if (!armed) begin
              armed <= 1'b1;
            end else if (cnt == PULSE_END) begin
              state   <= WAIT_LOCK;
              cnt     <= '0;
              pll_rst <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          WAIT_LOCK: begin
            if (lock_s) begin
              state <= STABLE;
              cnt   <= '0;
            end else if (timeout) begin
              state   <= PLL_RST;
              cnt     <= '0;
              pll_rst <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          STABLE: begin
            if (!lock_s) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == STABLE_END) begin
              state   <= SEQ;
              cnt     <= '0;
              idx     <= '0;
              rst_out <= rst_out & ~BIT0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          SEQ: begin
            if (idx == IDX_LAST) begin
              state  <= RUN;
              cnt    <= '0;
              locked <= 1'b1;
            end else if (cnt == GAP_END) begin
              idx     <= idx + IDX_W'(1);
              cnt     <= '0;
              rst_out <= rst_out & ~(BIT0 << (idx + IDX_W'(1)));
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RUN: begin
            locked <= 1'b1;
          end
          default: begin
            state   <= PLL_RST;
            cnt     <= '0;
            pll_rst <= 1'b1;
            rst_out <= '1;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
